t03_nes_button_receiver: RTL and testbench

Deserializes the NES controller's serial data line into an 8-bit button word. Sits directly downstream of the NES clock-divider/counter stage and consumes its `latch`, `button_en` and `finished` strobes. Filters frames so the published state changes only after consecutive identical frames, and produces one-cycle press/release event pulses for the game logic.

---
 rtl/t03_nes_button_receiver.sv | 199 +++++++++++++++++++
 tb/tb_t03_nes_button_receiver.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t03_nes_button_receiver.sv
// NES controller button receiver.
// Turns the controller's serial data line into a filtered 8-bit button word.
// The latch, button_en and finished strobes come from the upstream clock-divider/counter stage.
// A new button word is published only after STABLE_FRAMES consecutive identical good frames.
// Each change of the published word produces one-cycle pressed/released pulses.
module t03_nes_button_receiver #(
  parameter int STABLE_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nes_data,
  input  logic       latch,
  input  logic       button_en,
  input  logic       finished,
  output logic [7:0] buttons,
  output logic [7:0] pressed,
  output logic [7:0] released,
  output logic       frame_valid,
  output logic       frame_error
);

  // IDLE waits for the controller latch.
  // ARM waits for the latch to drop.
  // SHIFT collects bits.
  // EVAL judges the finished frame.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SHIFT = 2'd2,
    EVAL  = 2'd3
  } state_t;

  // Frame-stability threshold, narrowed to the width of the match counter.
  localparam logic [3:0] STABLE_Q = 4'(STABLE_FRAMES);

  // The bit counter saturates here; any value above 8 means the frame was too long.
  localparam logic [3:0] BIT_SAT = 4'd9;

  // The match counter saturates here.
  localparam logic [3:0] MATCH_MAX = 4'd15;

  state_t state, state_n;

  logic       sync1, d_s;
  logic       latch_q, finished_q;
  logic       latch_fall, latch_rise, finished_rise;

  logic [7:0] shreg, shreg_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] last_raw, last_raw_n;
  logic [3:0] match_cnt, match_cnt_n;
  logic [3:0] match_upd;

  logic [7:0] buttons_n, pressed_n, released_n;
  logic       valid_n, error_n;

  // The controller data line is asynchronous to clk, so it goes through two flops.
  // Both flops idle at 1, which means "not pressed".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      d_s   <= 1'b1;
    end else begin
      sync1 <= nes_data;
      d_s   <= sync1;
    end
  end

  // Delayed copies of latch and finished, used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_q    <= 1'b0;
      finished_q <= 1'b0;
    end else begin
      latch_q    <= latch;
      finished_q <= finished;
    end
  end

  assign latch_fall    = !latch && latch_q;
  assign latch_rise    = latch && !latch_q;
  assign finished_rise = finished && !finished_q;

  // Frame-tracking state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Datapath and output registers; every output is a plain flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      last_raw    <= '0;
      match_cnt   <= '0;
      buttons     <= '0;
      pressed     <= '0;
      released    <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      shreg       <= shreg_n;
      bit_cnt     <= bit_cnt_n;
      last_raw    <= last_raw_n;
      match_cnt   <= match_cnt_n;
      buttons     <= buttons_n;
      pressed     <= pressed_n;
      released    <= released_n;
      frame_valid <= valid_n;
      frame_error <= error_n;
    end
  end

  // Next-state and datapath decisions.
  // All pulse outputs default low, so they last exactly one cycle.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bit_cnt_n   = bit_cnt;
    last_raw_n  = last_raw;
    match_cnt_n = match_cnt;
    match_upd   = match_cnt;
    buttons_n   = buttons;
    pressed_n   = '0;
    released_n  = '0;
    valid_n     = 1'b0;
    error_n     = 1'b0;

    case (state)
      IDLE: begin
        if (latch) begin
          state_n = ARM;
        end
      end

      ARM: begin
        if (latch_fall) begin
          state_n   = SHIFT;
          shreg_n   = '0;
          bit_cnt_n = '0;
        end
      end

      SHIFT: begin
        if (latch_rise) begin
          // A new latch before the frame finished throws away the partial frame.
          state_n     = ARM;
          error_n     = 1'b1;
          match_cnt_n = '0;
        end else begin
          // The bit is captured before the finished check.
          // A strobe that coincides with finished therefore still counts toward this frame.
          if (button_en) begin
            if (bit_cnt < 4'd8) begin
              shreg_n[bit_cnt[2:0]] = ~d_s;
            end
            if (bit_cnt < BIT_SAT) begin
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
          if (finished_rise) begin
            state_n = EVAL;
          end
        end
      end

      EVAL: begin
        state_n = IDLE;
        if (bit_cnt != 4'd8) begin
          error_n     = 1'b1;
          match_cnt_n = '0;
        end else begin
          valid_n = 1'b1;
          if (shreg == last_raw) begin
            match_upd = (match_cnt == MATCH_MAX) ? MATCH_MAX : match_cnt + 4'd1;
          end else begin
            last_raw_n = shreg;
            match_upd  = 4'd1;
          end
          match_cnt_n = match_upd;
          if ((match_upd >= STABLE_Q) && (shreg != buttons)) begin
            pressed_n  = shreg & ~buttons;
            released_n = ~shreg & buttons;
            buttons_n  = shreg;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_t03_nes_button_receiver.sv
// Self-checking bench for t03_nes_button_receiver.
// Two copies of the receiver are driven with the same stimulus, one with STABLE_FRAMES=1 and one with 2.
// A frame-level model predicts every output on every cycle.
// A directed table of hand-computed results pins the model.
module tb_t03_nes_button_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       nes_data;
  logic       latch;
  logic       button_en;
  logic       finished;

  logic [7:0] buttons_k1, pressed_k1, released_k1;
  logic [7:0] buttons_k2, pressed_k2, released_k2;
  logic       valid_k1, error_k1, valid_k2, error_k2;

  int checks = 0;
  int errors = 0;

  // Frame-level model state, one entry per instance.
  int         stable_k[2] = '{1, 2};
  logic [7:0] m_buttons[2];
  logic [7:0] m_last[2];
  int         m_match[2];
  logic [7:0] exp_pressed[2];
  logic [7:0] exp_released[2];
  logic       exp_valid[2];
  logic       exp_error[2];

  // One pending frame result, scheduled for the cycle on which it must appear.
  int         cycle = 0;
  bit         pend = 1'b0;
  int         pend_cycle;
  bit         pend_abort;
  logic [7:0] pend_bits;
  int         pend_n;
  int         fin_cycle;
  bit         cmp_en = 1'b0;

  logic [7:0] snap_b[2], snap_p[2], snap_r[2];
  logic       snap_v[2], snap_e[2], snap_abort_err[2];

  typedef struct {
    logic [7:0] bits;
    int         n;
    bit         abort;
    bit         coin;
    logic [7:0] b1, p1, r1;
    logic [7:0] b2, p2, r2;
    bit         v;
    bit         e;
  } lit_t;

  lit_t dir_tab[14];

  t03_nes_button_receiver #(.STABLE_FRAMES(1)) u_dut_k1 (
    .clk(clk), .rst(rst), .nes_data(nes_data), .latch(latch),
    .button_en(button_en), .finished(finished),
    .buttons(buttons_k1), .pressed(pressed_k1), .released(released_k1),
    .frame_valid(valid_k1), .frame_error(error_k1)
  );

  t03_nes_button_receiver #(.STABLE_FRAMES(2)) u_dut_k2 (
    .clk(clk), .rst(rst), .nes_data(nes_data), .latch(latch),
    .button_en(button_en), .finished(finished),
    .buttons(buttons_k2), .pressed(pressed_k2), .released(released_k2),
    .frame_valid(valid_k2), .frame_error(error_k2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] dut_out(input int idx, input int sel);
    logic [7:0] r;
    r = 8'h00;
    case (sel)
      0: r = (idx == 0) ? buttons_k1 : buttons_k2;
      1: r = (idx == 0) ? pressed_k1 : pressed_k2;
      2: r = (idx == 0) ? released_k1 : released_k2;
      3: r = {7'b0, (idx == 0) ? valid_k1 : valid_k2};
      default: r = {7'b0, (idx == 0) ? error_k1 : error_k2};
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_buttons[i]    = 8'h00;
      m_last[i]       = 8'h00;
      m_match[i]      = 0;
      exp_pressed[i]  = 8'h00;
      exp_released[i] = 8'h00;
      exp_valid[i]    = 1'b0;
      exp_error[i]    = 1'b0;
    end
    pend = 1'b0;
  endtask

  // Frame outcome from the receiver's rules.
  // An aborted frame, or one with a bit count other than 8, is an error and clears the match run.
  // A good frame extends or restarts the run, then publishes the frame once the run is long enough.
  task automatic model_apply(input int i);
    if (pend_abort || pend_n != 8) begin
      exp_error[i] = 1'b1;
      m_match[i]   = 0;
    end else begin
      exp_valid[i] = 1'b1;
      if (pend_bits == m_last[i]) begin
        m_match[i] = (m_match[i] >= 15) ? 15 : m_match[i] + 1;
      end else begin
        m_last[i]  = pend_bits;
        m_match[i] = 1;
      end
      if (m_match[i] >= stable_k[i] && pend_bits != m_buttons[i]) begin
        exp_pressed[i]  = pend_bits & ~m_buttons[i];
        exp_released[i] = ~pend_bits & m_buttons[i];
        m_buttons[i]    = pend_bits;
      end
    end
  endtask

  // Advance the model one clock; pulses live for a single cycle.
  always @(posedge clk) begin
    cycle = cycle + 1;
    for (int i = 0; i < 2; i++) begin
      exp_pressed[i]  = 8'h00;
      exp_released[i] = 8'h00;
      exp_valid[i]    = 1'b0;
      exp_error[i]    = 1'b0;
    end
    if (rst) begin
      pend = 1'b0;
    end else if (pend && cycle == pend_cycle) begin
      pend = 1'b0;
      for (int i = 0; i < 2; i++) model_apply(i);
    end
  end

  // Compare every output of both instances against the model on each falling edge.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("k%0d buttons", stable_k[i]), dut_out(i, 0), m_buttons[i]);
        checkOutput($sformatf("k%0d pressed", stable_k[i]), dut_out(i, 1), exp_pressed[i]);
        checkOutput($sformatf("k%0d released", stable_k[i]), dut_out(i, 2), exp_released[i]);
        checkOutput($sformatf("k%0d frame_valid", stable_k[i]), dut_out(i, 3), {7'b0, exp_valid[i]});
        checkOutput($sformatf("k%0d frame_error", stable_k[i]), dut_out(i, 4), {7'b0, exp_error[i]});
      end
    end
  end

  task automatic take_snapshot();
    for (int i = 0; i < 2; i++) begin
      snap_b[i] = dut_out(i, 0);
      snap_p[i] = dut_out(i, 1);
      snap_r[i] = dut_out(i, 2);
      snap_v[i] = dut_out(i, 3) != 8'h00;
      snap_e[i] = dut_out(i, 4) != 8'h00;
    end
  endtask

  task automatic latch_pulse();
    @(negedge clk);
    latch = 1'b1;
    repeat (3) @(negedge clk);
    latch = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Present one bit (1 = pressed) for three cycles before strobing it.
  // The strobe can optionally coincide with the rise of finished.
  task automatic send_bit(input bit b, input bit with_finish);
    @(negedge clk);
    nes_data = ~b;
    repeat (3) @(negedge clk);
    button_en = 1'b1;
    if (with_finish) begin
      finished  = 1'b1;
      fin_cycle = cycle;
    end
    @(negedge clk);
    button_en = 1'b0;
  endtask

  // Strobes while the receiver is idle; these must have no effect.
  task automatic stray_strobes();
    @(negedge clk);
    button_en = 1'b1;
    @(negedge clk);
    button_en = 1'b0;
    finished  = 1'b1;
    @(negedge clk);
    finished = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Drive one complete frame of n strobes.
  // If abort is set, the frame is preceded by a partial frame that a new latch aborts.
  task automatic applyStimulus(input logic [7:0] bits, input int n, input bit abort, input bit coin);
    latch_pulse();
    if (abort) begin
      for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
      @(negedge clk);
      latch      = 1'b1;
      pend_abort = 1'b1;
      pend_n     = 0;
      pend_bits  = 8'h00;
      pend_cycle = cycle + 1;
      pend       = 1'b1;
      @(negedge clk);
      snap_abort_err[0] = error_k1;
      snap_abort_err[1] = error_k2;
      repeat (2) @(negedge clk);
      latch = 1'b0;
      repeat (2) @(negedge clk);
    end
    for (int i = 0; i < n; i++) begin
      send_bit((i < 8) ? bits[i] : 1'($urandom_range(0, 1)), coin && (i == n - 1));
    end
    if (!coin) begin
      @(negedge clk);
      finished  = 1'b1;
      fin_cycle = cycle;
    end
    pend_abort = 1'b0;
    pend_bits  = bits;
    pend_n     = n;
    pend_cycle = fin_cycle + 2;
    pend       = 1'b1;
    while (cycle < fin_cycle + 2) @(negedge clk);
    take_snapshot();
    @(negedge clk);
    finished = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      for (int s = 0; s < 5; s++) begin
        checkOutput($sformatf("%s k%0d out%0d", tag, stable_k[i], s), dut_out(i, s), 8'h00);
      end
    end
  endtask

  initial begin
    logic [7:0] pool[4];
    int         kind;

    dir_tab = '{
      '{8'h09, 8, 1'b0, 1'b0, 8'h09, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0},
      '{8'h10, 8, 1'b0, 1'b0, 8'h10, 8'h10, 8'h09, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0},
      '{8'h10, 8, 1'b0, 1'b0, 8'h10, 8'h00, 8'h00, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0},
      '{8'h20, 8, 1'b0, 1'b0, 8'h20, 8'h20, 8'h10, 8'h10, 8'h00, 8'h00, 1'b1, 1'b0},
      '{8'h20, 8, 1'b0, 1'b0, 8'h20, 8'h00, 8'h00, 8'h20, 8'h20, 8'h10, 1'b1, 1'b0},
      '{8'h40, 8, 1'b0, 1'b0, 8'h40, 8'h40, 8'h20, 8'h20, 8'h00, 8'h00, 1'b1, 1'b0},
      '{8'h40, 7, 1'b0, 1'b0, 8'h40, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 1'b0, 1'b1},
      '{8'h40, 8, 1'b0, 1'b0, 8'h40, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 1'b1, 1'b0},
      '{8'h40, 8, 1'b0, 1'b0, 8'h40, 8'h00, 8'h00, 8'h40, 8'h40, 8'h20, 1'b1, 1'b0},
      '{8'h40, 9, 1'b0, 1'b0, 8'h40, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 1'b0, 1'b1},
      '{8'h40, 8, 1'b1, 1'b0, 8'h40, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 1'b1, 1'b0},
      '{8'h81, 8, 1'b0, 1'b1, 8'h81, 8'h81, 8'h40, 8'h40, 8'h00, 8'h00, 1'b1, 1'b0},
      '{8'h81, 8, 1'b0, 1'b1, 8'h81, 8'h00, 8'h00, 8'h81, 8'h81, 8'h40, 1'b1, 1'b0},
      '{8'h81, 8, 1'b0, 1'b0, 8'h81, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 1'b1, 1'b0}
    };

    rst       = 1'b1;
    nes_data  = 1'b1;
    latch     = 1'b0;
    button_en = 1'b0;
    finished  = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero_outputs("reset");
    cmp_en = 1'b1;

    $display("[TB] directed frames");
    for (int r = 0; r < 14; r++) begin
      applyStimulus(dir_tab[r].bits, dir_tab[r].n, dir_tab[r].abort, dir_tab[r].coin);
      if (dir_tab[r].abort) begin
        checkOutput($sformatf("dir%0d k1 abort error", r), {7'b0, snap_abort_err[0]}, 8'h01);
        checkOutput($sformatf("dir%0d k2 abort error", r), {7'b0, snap_abort_err[1]}, 8'h01);
      end
      checkOutput($sformatf("dir%0d k1 buttons", r), snap_b[0], dir_tab[r].b1);
      checkOutput($sformatf("dir%0d k1 pressed", r), snap_p[0], dir_tab[r].p1);
      checkOutput($sformatf("dir%0d k1 released", r), snap_r[0], dir_tab[r].r1);
      checkOutput($sformatf("dir%0d k2 buttons", r), snap_b[1], dir_tab[r].b2);
      checkOutput($sformatf("dir%0d k2 pressed", r), snap_p[1], dir_tab[r].p2);
      checkOutput($sformatf("dir%0d k2 released", r), snap_r[1], dir_tab[r].r2);
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("dir%0d k%0d valid", r, stable_k[i]), {7'b0, snap_v[i]}, {7'b0, dir_tab[r].v});
        checkOutput($sformatf("dir%0d k%0d error", r, stable_k[i]), {7'b0, snap_e[i]}, {7'b0, dir_tab[r].e});
      end
    end

    $display("[TB] random frames");
    pool[0] = 8'h00;
    pool[1] = 8'h81;
    pool[2] = 8'h3C;
    pool[3] = 8'($urandom);
    for (int f = 0; f < 80; f++) begin
      if ($urandom_range(0, 4) == 0) stray_strobes();
      kind = $urandom_range(0, 9);
      case (kind)
        0: applyStimulus(pool[$urandom_range(0, 3)], 7, 1'b0, 1'($urandom_range(0, 1)));
        1: applyStimulus(pool[$urandom_range(0, 3)], 9, 1'b0, 1'($urandom_range(0, 1)));
        2: applyStimulus(pool[$urandom_range(0, 3)], 8, 1'b1, 1'($urandom_range(0, 1)));
        default: applyStimulus(pool[$urandom_range(0, 3)], 8, 1'b0, 1'($urandom_range(0, 1)));
      endcase
    end

    $display("[TB] reset in the middle of a frame");
    applyStimulus(8'h5A, 8, 1'b0, 1'b0);
    applyStimulus(8'h5A, 8, 1'b0, 1'b0);
    checkOutput("pre-reset k2 buttons", buttons_k2, 8'h5A);
    latch_pulse();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_zero_outputs("async reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(8'h09, 8, 1'b0, 1'b0);
    checkOutput("post-reset f1 k1 buttons", snap_b[0], 8'h09);
    checkOutput("post-reset f1 k1 pressed", snap_p[0], 8'h09);
    checkOutput("post-reset f1 k2 buttons", snap_b[1], 8'h00);
    applyStimulus(8'h09, 8, 1'b0, 1'b0);
    checkOutput("post-reset f2 k2 buttons", snap_b[1], 8'h09);
    checkOutput("post-reset f2 k2 pressed", snap_p[1], 8'h09);
    checkOutput("post-reset f2 k1 pressed", snap_p[0], 8'h00);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
